axi_burst_master: RTL and testbench

- Upstream AXI master that feeds axi_ddr4_slave_model.
- Accepts one linear copy command: direction, byte address and word count.
- Splits the command into INCR bursts of at most MAX_BURST beats; no burst crosses a 4 KB boundary.
- Moves write data from a valid/ready stream onto AW/W/B, and read data from AR/R onto a valid/ready stream. One burst is outstanding at a time.

---
 rtl/axi_burst_master.sv | 209 ++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// Linear copy engine for one AXI4 master port. A command is split into INCR bursts
// (at most MAX_BURST beats, never across a 4 KB page), with one burst outstanding at a time.
module axi_burst_master #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int MAX_BURST      = 16,
    parameter int CNT_WIDTH      = 16,
    parameter int AXI_ID         = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [CNT_WIDTH-1:0]      cmd_words,
    output logic                      cmd_done,
    output logic                      cmd_err,
    input  logic [AXI_DATA_WIDTH-1:0] wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    output logic [AXI_DATA_WIDTH-1:0] rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [AXI_ID_WIDTH-1:0]   awid,
    output logic [AXI_ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]                awlen,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [AXI_DATA_WIDTH-1:0] wdata,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [AXI_ID_WIDTH-1:0]   bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic [AXI_ID_WIDTH-1:0]   arid,
    output logic [AXI_ADDR_WIDTH-1:0] araddr,
    output logic [7:0]                arlen,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [AXI_ID_WIDTH-1:0]   rid,
    input  logic [AXI_DATA_WIDTH-1:0] rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    input  logic                      rlast,
    output logic                      rready
);

    // state | meaning
    // IDLE  | waiting for a command (cmd_ready high)
    // CALC  | size the next burst: min(remaining, MAX_BURST, beats to 4 KB page end)
    // AW    | write address presented until awready
    // W     | write stream passed through to W channel
    // B     | waiting for the write response
    // AR    | read address presented until arready
    // R     | R channel passed through to the read stream
    // DONE  | cmd_done / cmd_err pulse
    typedef enum logic [2:0] {IDLE, CALC, AW, W, B, AR, R, DONE} state_t;

    localparam int BPB   = AXI_DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BPB);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BPB - 1);

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]      remaining;
    logic [8:0]                beats;
    logic [8:0]                beats_left;
    logic                      dir_wr;
    logic                      err;
    logic [AXI_ADDR_WIDTH-1:0] ax_addr;
    logic [7:0]                ax_len;

    logic [12:0]               to4k;
    logic [8:0]                beats_c;
    logic [AXI_ADDR_WIDTH-1:0] step;
    logic [CNT_WIDTH-1:0]      rem_next;
    logic                      last_beat;
    logic                      resp_err;
    logic                      err_next;
    logic                      unused;

    always_comb begin
        to4k    = (13'd4096 - {1'b0, addr[11:0]}) >> OFF_W;
        beats_c = 9'(MAX_BURST);
        if (32'(remaining) < 32'(beats_c)) beats_c = 9'(remaining);
        if (32'(to4k) < 32'(beats_c))      beats_c = 9'(to4k);
    end

    assign step      = AXI_ADDR_WIDTH'(beats) << OFF_W;
    assign rem_next  = remaining - CNT_WIDTH'(beats);
    assign last_beat = (beats_left == 9'd1);
    // A read beat is in error on a bad response or when rlast disagrees with our own count.
    assign resp_err  = (state == B) ? (bresp != 2'b00)
                                    : ((rresp != 2'b00) || (rlast != last_beat));
    assign err_next  = err | resp_err;

    assign awid     = AXI_ID_WIDTH'(AXI_ID);
    assign arid     = AXI_ID_WIDTH'(AXI_ID);
    assign awaddr   = ax_addr;
    assign araddr   = ax_addr;
    assign awlen    = ax_len;
    assign arlen    = ax_len;
    assign wvalid   = (state == W) && wr_valid;
    assign wdata    = wr_data;
    assign wr_ready = (state == W) && wready;
    assign wlast    = (state == W) && last_beat;
    assign rd_valid = (state == R) && rvalid;
    assign rd_data  = rdata;
    assign rready   = (state == R) && rd_ready;
    assign unused   = ^{bid, rid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            cmd_done   <= 1'b0;
            cmd_err    <= 1'b0;
            addr       <= '0;
            remaining  <= '0;
            beats      <= '0;
            beats_left <= '0;
            dir_wr     <= 1'b0;
            err        <= 1'b0;
            ax_addr    <= '0;
            ax_len     <= '0;
            awvalid    <= 1'b0;
            arvalid    <= 1'b0;
            bready     <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr      <= cmd_addr & ALIGN_MASK;
                        remaining <= cmd_words;
                        dir_wr    <= cmd_write;
                        err       <= 1'b0;
                        if (cmd_words == '0) begin
                            state    <= DONE;
                            cmd_done <= 1'b1;
                            cmd_err  <= 1'b0;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    beats      <= beats_c;
                    beats_left <= beats_c;
                    ax_addr    <= addr;
                    ax_len     <= 8'(beats_c - 9'd1);
                    if (dir_wr) begin
                        awvalid <= 1'b1;
                        state   <= AW;
                    end else begin
                        arvalid <= 1'b1;
                        state   <= AR;
                    end
                end
                AW: if (awready) begin
                    awvalid <= 1'b0;
                    state   <= W;
                end
                W: if (wvalid && wready) begin
                    beats_left <= beats_left - 9'd1;
                    if (last_beat) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                AR: if (arready) begin
                    arvalid <= 1'b0;
                    state   <= R;
                end
                B, R: begin
                    if ((state == B) ? bvalid : (rvalid && rready)) begin
                        err <= err_next;
                        if (state == R) beats_left <= beats_left - 9'd1;
                        if (state == B || last_beat) begin
                            bready    <= 1'b0;
                            addr      <= addr + step;
                            remaining <= rem_next;
                            if (rem_next != '0) begin
                                state <= CALC;
                            end else begin
                                state    <= DONE;
                                cmd_done <= 1'b1;
                                cmd_err  <= err_next;
                            end
                        end
                    end
                end
                DONE: begin
                    cmd_err   <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: a behavioural AXI slave with memory, a table of
// copy commands with hand-computed burst splits and data, plus a mid-command reset sequence.
module tb_axi_burst_master;

    localparam int WR_LAT = 100;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_done, cmd_err;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_words;
    logic [63:0] wr_data, rd_data, wdata, rdata;
    logic        wr_valid, wr_ready, rd_valid, rd_ready;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rlast, rready;
    logic [1:0]  bresp, rresp;

    axi_burst_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_words(cmd_words), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Slave model state
    logic [63:0] mem [logic [31:0]];
    logic [31:0] aw_a[$], ar_a[$];
    logic [7:0]  aw_l[$], ar_l[$];
    logic [63:0] wq[$], rq[$];
    int          cyc = 0, done_cnt = 0, done_cyc = 0, last_w_cyc = 0;
    logic        last_err = 1'b0;
    int          inj = 0;
    bit          rtog = 0;
    logic [31:0] w_addr, r_addr;
    int          w_len, w_beat, r_len, r_beat, b_timer;
    bit          b_pending = 0, r_active = 0, aw_stall = 0;
    logic [39:0] aw_hold;

    function automatic logic [63:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {32'h0, a};
    endfunction

    initial begin
        {awready, wready, bvalid, arready, rvalid, rlast, wr_valid, rd_ready} = '0;
        {bid, rid, bresp, rresp} = '0;
        wr_data = '0;
        rdata   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_pending = 0; r_active = 0; aw_stall = 0;
                wq.delete();
                {awready, wready, bvalid, arready, rvalid, rlast, wr_valid, rd_ready} = '0;
                #1;
            end else begin
                awready  = (cyc % 2) == 0;
                arready  = (cyc % 3) != 0;
                wready   = (cyc % 5) != 4;
                wr_valid = (wq.size() > 0) && ((cyc % 4) != 3);
                wr_data  = (wq.size() > 0) ? wq[0] : 64'h0;
                bvalid   = b_pending && (b_timer == 0);
                bresp    = (inj == 1) ? 2'b10 : 2'b00;
                rvalid   = r_active && ((cyc % 3) != 2);
                rdata    = r_active ? memrd(r_addr + 32'(r_beat * 8)) : 64'h0;
                rlast    = r_active && ((r_beat == r_len) ^ ((inj == 2) && (r_beat == 0)));
                rresp    = (inj == 1) ? 2'b10 : 2'b00;
                rd_ready = rtog ? ((cyc % 2) == 0) : 1'b1;
                #1;
                if (cmd_done) begin
                    done_cnt++;
                    last_err = cmd_err;
                    done_cyc = cyc;
                end
                if (awvalid) begin
                    if (aw_stall) chk("aw_stable", {awaddr, awlen}, aw_hold);
                    aw_stall = !awready;
                    aw_hold  = {awaddr, awlen};
                end else aw_stall = 0;
                if (awvalid && awready) begin
                    aw_a.push_back(awaddr); aw_l.push_back(awlen);
                    w_addr = awaddr; w_len = int'(awlen); w_beat = 0;
                end
                if (bvalid && bready) b_pending = 0;
                else if (b_pending && b_timer > 0) b_timer--;
                if (wvalid && wready) begin
                    chk("wlast", wlast, (w_beat == w_len));
                    if (wq.size() > 0) begin
                        chk("wdata", wdata, wq[0]);
                        void'(wq.pop_front());
                    end
                    mem[w_addr + 32'(w_beat * 8)] = wdata;
                    if (w_beat == w_len) begin
                        b_pending = 1; b_timer = WR_LAT; last_w_cyc = cyc;
                    end
                    w_beat++;
                end
                if (r_active) begin
                    chk("rready_mirror", rready, rd_ready);
                    chk("rd_valid_mirror", rd_valid, rvalid);
                    if (rvalid && rready) begin
                        rq.push_back(rd_data);
                        r_beat++;
                        if (r_beat > r_len) r_active = 0;
                    end
                end
                if (arvalid && arready) begin
                    ar_a.push_back(araddr); ar_l.push_back(arlen);
                    r_active = 1; r_addr = araddr; r_len = int'(arlen); r_beat = 0;
                end
            end
            cyc++;
        end
    end

    typedef struct {
        bit               wr;
        logic [31:0]      addr;
        int               words;
        logic [63:0]      base;
        bit               addr_data;
        int               inj;
        bit               tog;
        bit               lat;
        bit               exp_err;
        int               nb;
        logic [2:0][31:0] ba;
        logic [2:0][7:0]  bl;
    } vec_t;

    function automatic vec_t mk(input bit wr, input logic [31:0] a, input int n,
                                input logic [63:0] base, input bit ad, input int ij,
                                input bit tg, input bit lt, input bit er, input int nb,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [7:0] l0,
                                input logic [7:0] l1, input logic [7:0] l2);
        vec_t v;
        v.wr = wr; v.addr = a; v.words = n; v.base = base; v.addr_data = ad; v.inj = ij;
        v.tog = tg; v.lat = lt; v.exp_err = er; v.nb = nb;
        v.ba[0] = a0; v.ba[1] = a1; v.ba[2] = a2;
        v.bl[0] = l0; v.bl[1] = l1; v.bl[2] = l2;
        return v;
    endfunction

    task automatic issue(input bit wr, input logic [31:0] a, input int n, output bit ok);
        ok = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_words = 16'(n);
        for (int i = 0; i < 50; i++) begin
            #1;
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int          start;
        bit          ok;
        logic [31:0] qa[$];
        logic [7:0]  ql[$];
        logic [31:0] a0;
        logic [63:0] exp;
        aw_a.delete(); aw_l.delete(); ar_a.delete(); ar_l.delete(); rq.delete(); wq.delete();
        inj = v.inj; rtog = v.tog;
        if (v.wr) for (int i = 0; i < v.words; i++) wq.push_back(v.base + 64'(i));
        start = done_cnt;
        issue(v.wr, v.addr, v.words, ok);
        chk("cmd_accept", ok, 1);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #2;
            if (done_cnt > start) begin
                ok = 1;
                break;
            end
        end
        chk("cmd_done_seen", ok, 1);
        chk("cmd_err", last_err, v.exp_err);
        repeat (3) @(negedge clk);
        #2;
        chk("done_once", done_cnt - start, 1);
        chk("burst_count", aw_a.size() + ar_a.size(), v.nb);
        if (v.wr) begin qa = aw_a; ql = aw_l; end
        else begin qa = ar_a; ql = ar_l; end
        for (int i = 0; i < v.nb; i++) begin
            if (i < qa.size()) begin
                chk("burst_addr", qa[i], v.ba[i]);
                chk("burst_len", ql[i], v.bl[i]);
            end
        end
        if (!v.wr) begin
            a0 = v.addr & ~32'h7;
            chk("rd_beats", rq.size(), v.words);
            for (int i = 0; i < rq.size() && i < v.words; i++) begin
                exp = v.addr_data ? {32'h0, a0 + 32'(i * 8)} : v.base + 64'(i);
                chk("rd_data", rq[i], exp);
            end
        end else begin
            chk("wr_consumed", wq.size(), 0);
        end
        if (v.lat) chk("b_latency", ((done_cyc - last_w_cyc) >= 100) && ((done_cyc - last_w_cyc) <= 110), 1);
        inj = 0; rtog = 0;
    endtask

    vec_t vt[11];

    initial begin
        bit ok;
        int start;
        //            wr addr      n   base      ad inj tg lt er nb  a0        a1        a2       l0 l1 l2
        vt[0]  = mk(1, 32'h0,    40, 64'h1000, 0, 0, 0, 0, 0, 3, 32'h0,    32'h80,   32'h100, 15, 15, 7);
        vt[1]  = mk(1, 32'h100,   4, 64'hA0,   0, 0, 0, 1, 0, 1, 32'h100,  32'h0,    32'h0,    3,  0, 0);
        vt[2]  = mk(0, 32'h100,   4, 64'hA0,   0, 0, 1, 0, 0, 1, 32'h100,  32'h0,    32'h0,    3,  0, 0);
        vt[3]  = mk(0, 32'hFE0,   8, 64'h0,    1, 0, 0, 0, 0, 2, 32'hFE0,  32'h1000, 32'h0,    3,  3, 0);
        vt[4]  = mk(0, 32'h8,     6, 64'h1001, 0, 0, 0, 0, 0, 1, 32'h8,    32'h0,    32'h0,    5,  0, 0);
        vt[5]  = mk(1, 32'h207,   2, 64'hB0,   0, 1, 0, 0, 1, 1, 32'h200,  32'h0,    32'h0,    1,  0, 0);
        vt[6]  = mk(0, 32'h200,   2, 64'hB0,   0, 2, 0, 0, 1, 1, 32'h200,  32'h0,    32'h0,    1,  0, 0);
        vt[7]  = mk(1, 32'hFF8,  19, 64'hC00,  0, 0, 0, 0, 0, 3, 32'hFF8,  32'h1000, 32'h1080, 0, 15, 1);
        vt[8]  = mk(0, 32'h1000,  3, 64'hC01,  0, 0, 0, 0, 0, 1, 32'h1000, 32'h0,    32'h0,    2,  0, 0);
        vt[9]  = mk(0, 32'hFF8,   2, 64'hC00,  0, 1, 0, 0, 1, 2, 32'hFF8,  32'h1000, 32'h0,    0,  0, 0);
        vt[10] = mk(1, 32'h40,    0, 64'h0,    0, 0, 0, 0, 0, 0, 32'h0,    32'h0,    32'h0,    0,  0, 0);

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_words = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctrl", {cmd_ready, cmd_done, cmd_err, awvalid, wvalid, wlast, arvalid,
                         bready, rready, wr_ready, rd_valid}, 0);
        chk("rst_addr", {awaddr, araddr}, 0);
        chk("rst_len", {awlen, arlen}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_clk", cmd_ready, 0);
        @(negedge clk);
        #1;
        chk("ready_after_clk", cmd_ready, 1);

        for (int i = 0; i < 11; i++) run_vec(vt[i]);

        // Reset during the second burst of a 40-word write
        aw_a.delete(); aw_l.delete(); ar_a.delete(); ar_l.delete(); wq.delete();
        for (int i = 0; i < 40; i++) wq.push_back(64'h1000 + 64'(i));
        start = done_cnt;
        issue(1, 32'h0, 40, ok);
        chk("rst_seq_accept", ok, 1);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #2;
            if (aw_a.size() >= 2) begin
                ok = 1;
                break;
            end
        end
        chk("second_aw_seen", ok, 1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_valids", {awvalid, wvalid, wlast, arvalid, bready, rready, wr_ready,
                             rd_valid, cmd_ready, cmd_done}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_low", cmd_ready, 0);
        @(negedge clk);
        #1;
        chk("abort_ready_high", cmd_ready, 1);
        repeat (5) @(negedge clk);
        #2;
        chk("abort_no_done", done_cnt - start, 0);
        run_vec(mk(0, 32'h40, 2, 64'h1008, 0, 0, 0, 0, 0, 1, 32'h40, 32'h0, 32'h0, 1, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
